// File: rtl/ucsbece154b_victim_ctrl.sv
// Miss-path controller for the fully-associative victim cache: probes and fills the victim
// cache on each L1 miss, falls back to memory on a victim miss, and serializes flushes.
module ucsbece154b_victim_ctrl #(
  parameter int ADDR_WIDTH = 56,
  parameter int LINE_WIDTH = 128,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  miss_valid_i,
  output logic                  miss_ready_o,
  input  logic [ADDR_WIDTH-1:0] miss_addr_i,
  input  logic                  evict_valid_i,
  input  logic [ADDR_WIDTH-1:0] evict_addr_i,
  input  logic [LINE_WIDTH-1:0] evict_data_i,
  output logic                  refill_valid_o,
  input  logic                  refill_ready_i,
  output logic [LINE_WIDTH-1:0] refill_data_o,
  output logic                  refill_src_o,
  output logic                  vc_en_o,
  output logic                  vc_flush_o,
  output logic [ADDR_WIDTH-1:0] vc_raddr_o,
  input  logic [LINE_WIDTH-1:0] vc_rdata_i,
  input  logic                  vc_hit_i,
  output logic                  vc_we_o,
  output logic [ADDR_WIDTH-1:0] vc_waddr_o,
  output logic [LINE_WIDTH-1:0] vc_wdata_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [LINE_WIDTH-1:0] mem_rsp_data_i,
  output logic [CNT_WIDTH-1:0]  hit_cnt_o,
  output logic [CNT_WIDTH-1:0]  miss_cnt_o
);

  localparam int OFFSET_WIDTH = $clog2(LINE_WIDTH/8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    {{(ADDR_WIDTH-OFFSET_WIDTH){1'b1}}, {OFFSET_WIDTH{1'b0}}};

  // IDLE accept/flush | LOOKUP probe+evict write | MEM_REQ/MEM_WAIT fetch | RESP return line
  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MEM_REQ, S_MEM_WAIT, S_RESP
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_pending;
  logic                  r_vc_en;
  logic                  r_evict_valid;
  logic [ADDR_WIDTH-1:0] r_miss_addr;
  logic [ADDR_WIDTH-1:0] r_evict_addr;
  logic [LINE_WIDTH-1:0] r_evict_data;
  logic [LINE_WIDTH-1:0] r_refill_data;
  logic                  r_refill_src;
  logic [CNT_WIDTH-1:0]  r_hit_cnt;
  logic [CNT_WIDTH-1:0]  r_miss_cnt;

  logic w_miss_fire, w_flush_fire, w_lookup_hit, w_lookup_miss, w_rsp_fire;

  assign w_miss_fire   = (r_state == S_IDLE) && !r_pending && miss_valid_i;
  assign w_flush_fire  = (r_state == S_IDLE) && r_pending;
  assign w_lookup_hit  = (r_state == S_LOOKUP) && vc_hit_i;
  assign w_lookup_miss = (r_state == S_LOOKUP) && !vc_hit_i;
  assign w_rsp_fire    = (r_state == S_MEM_WAIT) && mem_rsp_valid_i;

  always_comb begin
    w_state_nxt     = r_state;
    miss_ready_o    = 1'b0;
    vc_flush_o      = 1'b0;
    vc_we_o         = 1'b0;
    mem_req_valid_o = 1'b0;
    refill_valid_o  = 1'b0;
    case (r_state)
      S_IDLE: begin
        miss_ready_o = !r_pending;
        vc_flush_o   = r_pending;
        if (w_miss_fire) w_state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        vc_we_o     = r_evict_valid;
        w_state_nxt = vc_hit_i ? S_RESP : S_MEM_REQ;
      end
      S_MEM_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) w_state_nxt = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (mem_rsp_valid_i) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        refill_valid_o = 1'b1;
        if (refill_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A flush request arriving in the same cycle as a clear re-arms the pending bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
      r_vc_en   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_vc_en <= 1'b1;
      if (flush_i)           r_pending <= 1'b1;
      else if (w_flush_fire) r_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_miss_addr   <= '0;
      r_evict_valid <= 1'b0;
      r_evict_addr  <= '0;
      r_evict_data  <= '0;
      r_refill_data <= '0;
      r_refill_src  <= 1'b0;
      r_hit_cnt     <= '0;
      r_miss_cnt    <= '0;
    end else begin
      if (w_miss_fire) begin
        r_miss_addr   <= miss_addr_i & ALIGN_MASK;
        r_evict_valid <= evict_valid_i;
        r_evict_addr  <= evict_addr_i & ALIGN_MASK;
        r_evict_data  <= evict_data_i;
      end
      if (w_lookup_hit) begin
        r_refill_data <= vc_rdata_i;
        r_refill_src  <= 1'b1;
        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_WIDTH'(1);
      end
      if (w_lookup_miss && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
      if (w_rsp_fire) begin
        r_refill_data <= mem_rsp_data_i;
        r_refill_src  <= 1'b0;
      end
    end
  end

  assign vc_en_o        = r_vc_en;
  assign vc_raddr_o     = r_miss_addr;
  assign mem_req_addr_o = r_miss_addr;
  assign vc_waddr_o     = r_evict_addr;
  assign vc_wdata_o     = r_evict_data;
  assign refill_data_o  = r_refill_data;
  assign refill_src_o   = r_refill_src;
  assign hit_cnt_o      = r_hit_cnt;
  assign miss_cnt_o     = r_miss_cnt;

endmodule

// File: tb/tb_ucsbece154b_victim_ctrl.sv
// Scoreboard bench for ucsbece154b_victim_ctrl: random misses/evictions/flushes against a
// map-based reference of victim-cache contents and memory, plus a CNT_WIDTH=2 twin.
module tb_ucsbece154b_victim_ctrl;
  localparam int AW = 56;
  localparam int LW = 128;
  localparam logic [AW-1:0] AMASK = {{(AW-4){1'b1}}, 4'h0};

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic          flush_i, miss_valid_i, miss_ready_o, evict_valid_i;
  logic [AW-1:0] miss_addr_i, evict_addr_i;
  logic [LW-1:0] evict_data_i;
  logic          refill_valid_o, refill_ready_i, refill_src_o;
  logic [LW-1:0] refill_data_o;
  logic          vc_en_o, vc_flush_o, vc_hit_i, vc_we_o;
  logic [AW-1:0] vc_raddr_o, vc_waddr_o, mem_req_addr_o;
  logic [LW-1:0] vc_rdata_i, vc_wdata_o, mem_rsp_data_i;
  logic          mem_req_valid_o, mem_req_ready_i, mem_rsp_valid_i;
  logic [31:0]   hit_cnt_o, miss_cnt_o;

  logic          s_miss_ready, s_refill_valid, s_refill_src, s_vc_en, s_vc_flush, s_vc_we, s_mem_req_valid;
  logic [LW-1:0] s_refill_data, s_vc_wdata;
  logic [AW-1:0] s_vc_raddr, s_vc_waddr, s_mem_req_addr;
  logic [1:0]    s_hit_cnt, s_miss_cnt;

  ucsbece154b_victim_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o), .miss_addr_i(miss_addr_i),
    .evict_valid_i(evict_valid_i), .evict_addr_i(evict_addr_i), .evict_data_i(evict_data_i),
    .refill_valid_o(refill_valid_o), .refill_ready_i(refill_ready_i),
    .refill_data_o(refill_data_o), .refill_src_o(refill_src_o),
    .vc_en_o(vc_en_o), .vc_flush_o(vc_flush_o), .vc_raddr_o(vc_raddr_o),
    .vc_rdata_i(vc_rdata_i), .vc_hit_i(vc_hit_i),
    .vc_we_o(vc_we_o), .vc_waddr_o(vc_waddr_o), .vc_wdata_o(vc_wdata_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_data_i(mem_rsp_data_i), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
  );

  ucsbece154b_victim_ctrl #(.CNT_WIDTH(2)) dut_sat (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .miss_valid_i(miss_valid_i), .miss_ready_o(s_miss_ready), .miss_addr_i(miss_addr_i),
    .evict_valid_i(evict_valid_i), .evict_addr_i(evict_addr_i), .evict_data_i(evict_data_i),
    .refill_valid_o(s_refill_valid), .refill_ready_i(refill_ready_i),
    .refill_data_o(s_refill_data), .refill_src_o(s_refill_src),
    .vc_en_o(s_vc_en), .vc_flush_o(s_vc_flush), .vc_raddr_o(s_vc_raddr),
    .vc_rdata_i(vc_rdata_i), .vc_hit_i(vc_hit_i),
    .vc_we_o(s_vc_we), .vc_waddr_o(s_vc_waddr), .vc_wdata_o(s_vc_wdata),
    .mem_req_valid_o(s_mem_req_valid), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(s_mem_req_addr), .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_data_i(mem_rsp_data_i), .hit_cnt_o(s_hit_cnt), .miss_cnt_o(s_miss_cnt)
  );

  typedef struct {
    logic [LW-1:0] data;
    logic          src;
    int            acc;
    int            hits;
    int            misses;
  } exp_t;

  exp_t          sb_q[$];
  logic [LW-1:0] ref_vc [logic [AW-1:0]];
  logic [LW-1:0] env_vc [logic [AW-1:0]];
  logic [LW-1:0] mem_ovr [logic [AW-1:0]];
  int ref_hits = 0, ref_misses = 0, mem_reqs = 0;
  int n_checks = 0, n_fail = 0;
  int cyc = 0, last_acc_cyc = -10, last_rsp_cyc = -10, last_done_cyc = -10;
  int mem_stall_force = 0, ref_stall_force = 0, rsp_delay_force = 0;
  logic mem_busy = 1'b0;
  logic [AW-1:0] mem_addr;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [LW-1:0] mem_data(input logic [AW-1:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return {a ^ 56'h3C_5A5A_0F0F_A5A5, 16'hC0DE, a};
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // victim cache environment: lookup sees contents before this cycle's write
  initial begin
    vc_hit_i = 1'b0;
    vc_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      if (env_vc.exists(vc_raddr_o)) begin
        vc_hit_i = 1'b1;
        vc_rdata_i = env_vc[vc_raddr_o];
      end else begin
        vc_hit_i = 1'b0;
        vc_rdata_i = {$urandom, $urandom, $urandom, $urandom};
      end
      if (vc_we_o) env_vc[vc_waddr_o] = vc_wdata_o;
      if (vc_flush_o || !vc_en_o) env_vc.delete();
    end
  end

  // memory environment
  initial begin
    logic pv, pr;
    logic [AW-1:0] pa;
    int stall, cnt;
    pv = 1'b0; pr = 1'b0; pa = '0; stall = 0; cnt = 0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i = '0;
    forever begin
      @(negedge clk_i);
      mem_rsp_valid_i = 1'b0;
      if (mem_busy) begin
        cnt--;
        if (cnt <= 0) begin
          mem_rsp_valid_i = 1'b1;
          mem_rsp_data_i = mem_data(mem_addr);
          mem_busy = 1'b0;
          last_rsp_cyc = cyc;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i = {$urandom, $urandom, $urandom, $urandom};
      end
      if (rst_ni && mem_req_valid_o) begin
        if (pv && !pr) begin
          check("mem_req_addr_stable", mem_req_addr_o, pa);
        end else begin
          check("mem_req_latency", cyc, last_acc_cyc + 2);
          check("mem_req_aligned", mem_req_addr_o[3:0], 4'h0);
          if (mem_stall_force > 0) begin stall = mem_stall_force; mem_stall_force = 0; end
        end
        if (stall > 0) begin
          mem_req_ready_i = 1'b0;
          stall--;
        end else if ($urandom_range(0, 3) == 0) begin
          mem_req_ready_i = 1'b0;
          stall = $urandom_range(0, 3);
        end else begin
          mem_req_ready_i = 1'b1;
        end
        if (mem_req_ready_i) begin
          check("single_mem_req", mem_busy, 1'b0);
          mem_busy = 1'b1;
          mem_addr = mem_req_addr_o;
          mem_reqs++;
          if (rsp_delay_force > 0) begin cnt = rsp_delay_force; rsp_delay_force = 0; end
          else cnt = $urandom_range(1, 4);
        end
      end else begin
        mem_req_ready_i = 1'($urandom_range(0, 1));
      end
      pv = rst_ni && mem_req_valid_o;
      pr = mem_req_ready_i;
      pa = mem_req_addr_o;
    end
  end

  // refill monitor / scoreboard consumer
  initial begin
    logic pv, pr, ps, pf, have;
    logic [LW-1:0] pd;
    exp_t cur;
    int stall;
    pv = 1'b0; pr = 1'b0; ps = 1'b0; pf = 1'b0; have = 1'b0; pd = '0; stall = 0;
    refill_ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        pv = 1'b0; pr = 1'b0; pf = 1'b0; have = 1'b0; stall = 0;
        refill_ready_i = 1'b0;
        continue;
      end
      if (refill_valid_o) begin
        if (pv && !pr) begin
          check("refill_data_stable", refill_data_o, pd);
          check("refill_src_stable", refill_src_o, ps);
        end else if (sb_q.size() == 0) begin
          check("unexpected_refill", refill_valid_o, 1'b0);
          have = 1'b0;
        end else begin
          cur = sb_q[0];
          have = 1'b1;
          if (cur.src) check("hit_latency", cyc, cur.acc + 2);
          else         check("mem_latency", cyc, last_rsp_cyc + 1);
          check("hit_cnt", hit_cnt_o, cur.hits);
          check("miss_cnt", miss_cnt_o, cur.misses);
          check("hit_cnt_sat", s_hit_cnt, sat3(cur.hits));
          check("miss_cnt_sat", s_miss_cnt, sat3(cur.misses));
          if (ref_stall_force > 0) begin stall = ref_stall_force; ref_stall_force = 0; end
        end
        if (stall > 0) begin
          refill_ready_i = 1'b0;
          stall--;
        end else if ($urandom_range(0, 3) == 0) begin
          refill_ready_i = 1'b0;
          stall = $urandom_range(0, 3);
        end else begin
          refill_ready_i = 1'b1;
        end
        if (refill_ready_i && have) begin
          check("refill_data", refill_data_o, cur.data);
          check("refill_src", refill_src_o, cur.src);
          void'(sb_q.pop_front());
          have = 1'b0;
          last_done_cyc = cyc;
        end
      end else begin
        refill_ready_i = 1'($urandom_range(0, 1));
      end
      if (vc_flush_o) begin
        check("flush_blocks_miss", miss_ready_o, 1'b0);
        check("flush_one_cycle", pf, 1'b0);
      end
      pf = vc_flush_o;
      pv = refill_valid_o;
      pr = refill_ready_i;
      pd = refill_data_o;
      ps = refill_src_o;
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_miss_ready"}, miss_ready_o, 1'b1);
    check({tag, "_refill_valid"}, refill_valid_o, 1'b0);
    check({tag, "_vc_en"}, vc_en_o, 1'b0);
    check({tag, "_vc_flush"}, vc_flush_o, 1'b0);
    check({tag, "_vc_we"}, vc_we_o, 1'b0);
    check({tag, "_mem_req_valid"}, mem_req_valid_o, 1'b0);
    check({tag, "_refill_data"}, refill_data_o, '0);
    check({tag, "_refill_src"}, refill_src_o, 1'b0);
    check({tag, "_vc_raddr"}, vc_raddr_o, '0);
    check({tag, "_vc_waddr"}, vc_waddr_o, '0);
    check({tag, "_vc_wdata"}, vc_wdata_o, '0);
    check({tag, "_mem_req_addr"}, mem_req_addr_o, '0);
    check({tag, "_hit_cnt"}, hit_cnt_o, '0);
    check({tag, "_miss_cnt"}, miss_cnt_o, '0);
  endtask

  task automatic do_miss(input logic [AW-1:0] addr, input logic ev,
                         input logic [AW-1:0] ev_addr, input logic [LW-1:0] ev_data);
    logic [AW-1:0] a, ea;
    exp_t e;
    int n;
    a = addr & AMASK;
    ea = ev_addr & AMASK;
    @(negedge clk_i);
    miss_valid_i = 1'b1;
    miss_addr_i = addr;
    evict_valid_i = ev;
    evict_addr_i = ev_addr;
    evict_data_i = ev_data;
    n = 0;
    while (!miss_ready_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (!miss_ready_o) begin
      check("miss_accept_timeout", miss_ready_o, 1'b1);
      miss_valid_i = 1'b0;
      return;
    end
    e.src = ref_vc.exists(a);
    e.data = e.src ? ref_vc[a] : mem_data(a);
    if (e.src) ref_hits++;
    else       ref_misses++;
    if (ev) ref_vc[ea] = ev_data;
    e.acc = cyc;
    e.hits = ref_hits;
    e.misses = ref_misses;
    last_acc_cyc = cyc;
    sb_q.push_back(e);
    @(negedge clk_i);
    miss_valid_i = 1'b0;
    miss_addr_i = {$urandom, $urandom};
    evict_valid_i = 1'($urandom_range(0, 1));
    evict_addr_i = {$urandom, $urandom};
    evict_data_i = {$urandom, $urandom, $urandom, $urandom};
    check("lookup_raddr", vc_raddr_o, a);
    check("lookup_we", vc_we_o, ev);
    if (ev) begin
      check("lookup_waddr", vc_waddr_o, ea);
      check("lookup_wdata", vc_wdata_o, ev_data);
    end
    @(negedge clk_i);
    check("we_once", vc_we_o, 1'b0);
  endtask

  task automatic do_flush();
    @(negedge clk_i);
    flush_i = 1'b1;
    ref_vc.delete();
    @(negedge clk_i);
    flush_i = 1'b0;
  endtask

  task automatic wait_mem_busy();
    int n;
    n = 0;
    do begin
      @(negedge clk_i);
      #1;
      n++;
    end while (!mem_busy && n < 100);
    check("mem_req_seen", mem_busy, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    check("drain", sb_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_ni = 1'b0;
    flush_i = 1'b0;
    miss_valid_i = 1'b0;
    miss_addr_i = '0;
    evict_valid_i = 1'b0;
    evict_addr_i = '0;
    evict_data_i = '0;
    mem_ovr[56'h100] = 128'hDEAD;
    repeat (3) @(negedge clk_i);
    check_reset("por");
    rst_ni = 1'b1;
    check("vc_en_before_edge", vc_en_o, 1'b0);
    @(negedge clk_i);
    check("vc_en_after_edge", vc_en_o, 1'b1);

    // directed: memory path with stalls, eviction, victim hit
    mem_stall_force = 5;
    ref_stall_force = 3;
    do_miss(56'h100, 1'b0, '0, '0);
    do_miss(56'h200, 1'b1, 56'h100, 128'hBEEF);
    do_miss(56'h10F, 1'b0, '0, '0);
    drain();

    // directed: flush during MEM_WAIT is deferred, then the flushed line misses
    rsp_delay_force = 4;
    do_miss(56'h300, 1'b1, 56'h400, 128'h4444);
    wait_mem_busy();
    @(negedge clk_i);
    #1;
    flush_i = 1'b1;
    ref_vc.delete();
    @(negedge clk_i);
    #1;
    flush_i = 1'b0;
    n = 0;
    while (!vc_flush_o && n < 100) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    check("flush_seen", vc_flush_o, 1'b1);
    check("flush_after_done", cyc, last_done_cyc + 1);
    check("flush_miss_ready", miss_ready_o, 1'b0);
    @(negedge clk_i);
    #1;
    check("flush_pulse_end", vc_flush_o, 1'b0);
    do_miss(56'h400, 1'b0, '0, '0);
    drain();

    // random traffic over a small line pool
    for (int i = 0; i < 70; i++) begin
      logic [AW-1:0] ma, ea;
      logic ev;
      logic [LW-1:0] ed;
      ma = AW'(32'h1000 + ($urandom_range(0, 7) << 4) + $urandom_range(0, 15));
      ea = AW'(32'h1000 + ($urandom_range(0, 7) << 4) + $urandom_range(0, 15));
      ev = ($urandom_range(0, 9) < 6);
      ed = {$urandom, $urandom, $urandom, $urandom};
      do_miss(ma, ev, ea, ed);
      if ($urandom_range(0, 11) == 0) do_flush();
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end
    drain();
    check("enough_hits", (ref_hits >= 5), 1'b1);
    check("sat_hit_final", s_hit_cnt, sat3(ref_hits));
    check("hit_cnt_final", hit_cnt_o, ref_hits);
    check("miss_cnt_final", miss_cnt_o, ref_misses);
    check("mem_req_count", mem_reqs, ref_misses);

    // reset in MEM_WAIT; the late memory response must not produce a refill
    rsp_delay_force = 8;
    do_miss(56'h9990, 1'b1, 56'h1000, 128'h77);
    wait_mem_busy();
    @(negedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    check_reset("mid");
    sb_q.delete();
    ref_vc.delete();
    ref_hits = 0;
    ref_misses = 0;
    mem_reqs = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (15) @(negedge clk_i);
    check("late_rsp_busy_cleared", mem_busy, 1'b0);
    check("late_rsp_no_refill", refill_valid_o, 1'b0);
    do_miss(56'h1000, 1'b0, '0, '0);
    drain();
    check("post_reset_miss_cnt", miss_cnt_o, 1);
    check("post_reset_mem_reqs", mem_reqs, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
